// File: rtl/dest_encoder.sv
// dest_encoder: merges per-register write-request pulses and grants one destination index at a time.
// Ports: clk_i, rst_i (sync, active-high), req_i[7:0], ready_i -> destreg_o[2:0], valid_o, pending_cnt_o[3:0].
module dest_encoder (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       ready_i,
  output logic [2:0] destreg_o,
  output logic       valid_o,
  output logic [3:0] pending_cnt_o
);

  logic [7:0] pending;
  logic [2:0] ptr;

  logic [7:0] cand;
  logic       load_en;
  logic       hit;
  logic [2:0] idx;
  logic [2:0] pos;
  logic [7:0] clr_mask;

  assign cand    = pending | req_i;
  assign load_en = !valid_o | ready_i;

  // Walk from the farthest offset back to ptr so the
  // nearest set bit at or after ptr is the one kept.
  always_comb begin
    hit = 1'b0;
    idx = ptr;
    pos = ptr;
    for (int i = 7; i >= 0; i--) begin
      pos = ptr + 3'(i);
      if (cand[pos]) begin
        idx = pos;
        hit = 1'b1;
      end
    end
  end

  assign clr_mask = ~(8'b1 << idx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending   <= '0;
      ptr       <= '0;
      valid_o   <= 1'b0;
      destreg_o <= '0;
    end else if (load_en) begin
      if (hit) begin
        destreg_o <= idx;
        valid_o   <= 1'b1;
        ptr       <= idx + 3'd1;
        pending   <= cand & clr_mask;
      end else begin
        valid_o   <= 1'b0;
        pending   <= '0;
      end
    end else begin
      // Output stalled: absorb new requests, hold grant.
      pending <= cand;
    end
  end

  always_comb begin
    pending_cnt_o = '0;
    for (int i = 0; i < 8; i++) begin
      pending_cnt_o = pending_cnt_o + {3'b000, pending[i]};
    end
  end

endmodule

// File: tb/tb_dest_encoder.sv
// tb_dest_encoder: directed vectors with hand-computed grants for dest_encoder.
// Drives inputs 1ns after each rising edge and samples outputs there.
module tb_dest_encoder;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] req_i;
  logic       ready_i;
  logic [2:0] destreg_o;
  logic       valid_o;
  logic [3:0] pending_cnt_o;

  int checks = 0;
  int failures = 0;

  dest_encoder dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .ready_i(ready_i),
    .destreg_o(destreg_o),
    .valid_o(valid_o),
    .pending_cnt_o(pending_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = 8'h00;
    ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", {7'b0, valid_o}, 8'd0);
    chk("rst_dest", {5'b0, destreg_o}, 8'd0);
    chk("rst_cnt", {4'b0, pending_cnt_o}, 8'd0);

    // single request
    req_i = 8'h04; ready_i = 1'b1;
    step();
    chk("s_valid", {7'b0, valid_o}, 8'd1);
    chk("s_dest", {5'b0, destreg_o}, 8'd2);
    req_i = 8'h00;
    step();
    chk("s_idle", {7'b0, valid_o}, 8'd0);

    // all eight at once, one grant per cycle
    do_reset();
    req_i = 8'hFF; ready_i = 1'b1;
    step();
    req_i = 8'h00;
    for (int k = 0; k < 8; k++) begin
      chk("ff_valid", {7'b0, valid_o}, 8'd1);
      chk("ff_dest", {5'b0, destreg_o}, 8'(k));
      chk("ff_cnt", {4'b0, pending_cnt_o}, 8'(7 - k));
      step();
    end
    chk("ff_end_valid", {7'b0, valid_o}, 8'd0);
    chk("ff_end_cnt", {4'b0, pending_cnt_o}, 8'd0);

    // stalled output
    do_reset();
    req_i = 8'h81; ready_i = 1'b0;
    step();
    req_i = 8'h00;
    chk("st_valid", {7'b0, valid_o}, 8'd1);
    chk("st_dest", {5'b0, destreg_o}, 8'd0);
    chk("st_cnt", {4'b0, pending_cnt_o}, 8'd1);
    step();
    chk("st_hold_dest", {5'b0, destreg_o}, 8'd0);
    chk("st_hold_valid", {7'b0, valid_o}, 8'd1);
    ready_i = 1'b1;
    step();
    chk("st_dest7", {5'b0, destreg_o}, 8'd7);
    chk("st_cnt0", {4'b0, pending_cnt_o}, 8'd0);
    step();
    chk("st_idle", {7'b0, valid_o}, 8'd0);

    // pointer wrap
    do_reset();
    req_i = 8'h20; ready_i = 1'b1;
    step();
    chk("wr_dest5", {5'b0, destreg_o}, 8'd5);
    req_i = 8'h21;
    step();
    req_i = 8'h00;
    chk("wr_dest0", {5'b0, destreg_o}, 8'd0);
    step();
    chk("wr_dest5b", {5'b0, destreg_o}, 8'd5);
    chk("wr_valid", {7'b0, valid_o}, 8'd1);
    step();
    chk("wr_idle", {7'b0, valid_o}, 8'd0);

    // re-request of the index in the output register
    do_reset();
    req_i = 8'h08; ready_i = 1'b0;
    step();
    chk("rr_dest", {5'b0, destreg_o}, 8'd3);
    chk("rr_cnt0", {4'b0, pending_cnt_o}, 8'd0);
    step();
    req_i = 8'h00;
    chk("rr_cnt1", {4'b0, pending_cnt_o}, 8'd1);
    chk("rr_hold", {5'b0, destreg_o}, 8'd3);
    ready_i = 1'b1;
    step();
    chk("rr_again_valid", {7'b0, valid_o}, 8'd1);
    chk("rr_again_dest", {5'b0, destreg_o}, 8'd3);
    chk("rr_again_cnt", {4'b0, pending_cnt_o}, 8'd0);
    step();
    chk("rr_idle", {7'b0, valid_o}, 8'd0);

    // duplicate pending request merges
    do_reset();
    req_i = 8'h03; ready_i = 1'b0;
    step();
    chk("dup_dest", {5'b0, destreg_o}, 8'd0);
    req_i = 8'h02;
    step();
    req_i = 8'h00;
    chk("dup_cnt", {4'b0, pending_cnt_o}, 8'd1);
    ready_i = 1'b1;
    step();
    chk("dup_dest1", {5'b0, destreg_o}, 8'd1);
    step();
    chk("dup_idle", {7'b0, valid_o}, 8'd0);

    // reset mid-operation discards everything
    do_reset();
    req_i = 8'hF8; ready_i = 1'b0;
    step();
    req_i = 8'h00;
    chk("mr_dest", {5'b0, destreg_o}, 8'd3);
    chk("mr_cnt", {4'b0, pending_cnt_o}, 8'd4);
    rst_i = 1'b1; req_i = 8'hFF;
    step();
    rst_i = 1'b0; req_i = 8'h00; ready_i = 1'b1;
    chk("mr_valid", {7'b0, valid_o}, 8'd0);
    chk("mr_dest0", {5'b0, destreg_o}, 8'd0);
    chk("mr_cnt0", {4'b0, pending_cnt_o}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mr_quiet", {7'b0, valid_o}, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
